d_latch_bank: RTL and testbench

Parametrised successor to the single-bit D latch. It holds a bank of DEPTH channels, each WIDTH bits wide, written under one of four modes: edge capture, gated transparent-latch emulation, shift chain, or freeze. Readback is registered, with per-channel change-tracking flags and a saturating write counter. It sits behind the Tiny Tapeout user-project wrapper: `ui_in` and `uio_in` drive data and control, and `uo_out` carries readback.

---
 rtl/d_latch_bank.sv | 109 ++++++++++
 tb/tb_d_latch_bank.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/d_latch_bank.sv
// rtl/d_latch_bank.sv - multi-channel D latch bank with capture, latch, shift and freeze write modes
// Registered readback, per-channel change flags and a saturating write counter.
module d_latch_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    waddr,
  input  logic [AW-1:0]    raddr,
  input  logic [1:0]       mode,
  input  logic             we,
  input  logic             gate,
  input  logic             clr_dirty,
  output logic [WIDTH-1:0] q,
  output logic [DEPTH-1:0] dirty,
  output logic [7:0]       wr_count
);

  localparam logic [1:0] MODE_CAPTURE = 2'b00;
  localparam logic [1:0] MODE_LATCH   = 2'b01;
  localparam logic [1:0] MODE_SHIFT   = 2'b10;

  logic [WIDTH-1:0] bank     [DEPTH];
  logic [WIDTH-1:0] bank_nxt [DEPTH];
  logic [DEPTH-1:0] wr_mask;
  logic [DEPTH-1:0] dirty_nxt;
  logic             gate_open;
  logic             gate_open_nxt;
  logic [AW-1:0]    lat_addr;
  logic [AW-1:0]    lat_addr_nxt;
  logic [AW-1:0]    lat_target;

  // An open latch window keeps writing the channel it opened on.
  assign lat_target = gate_open ? lat_addr : waddr;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      bank_nxt[i] = bank[i];
    end
    wr_mask       = '0;
    gate_open_nxt = 1'b0;
    lat_addr_nxt  = lat_addr;
    case (mode)
      MODE_CAPTURE: begin
        if (we) begin
          bank_nxt[waddr] = d;
          wr_mask[waddr]  = 1'b1;
        end
      end
      MODE_LATCH: begin
        if (gate) begin
          gate_open_nxt        = 1'b1;
          lat_addr_nxt         = lat_target;
          bank_nxt[lat_target] = d;
          wr_mask[lat_target]  = 1'b1;
        end
      end
      MODE_SHIFT: begin
        if (we) begin
          bank_nxt[0] = d;
          for (int i = 1; i < DEPTH; i++) begin
            bank_nxt[i] = bank[i-1];
          end
          wr_mask = '1;
        end
      end
      default: begin
      end
    endcase
  end

  // Set beats clear when both land on the same channel.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      dirty_nxt[i] = dirty[i] & ~(clr_dirty && (raddr == AW'(i)));
      if (wr_mask[i] && (bank_nxt[i] != bank[i])) begin
        dirty_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
      q         <= '0;
      dirty     <= '0;
      wr_count  <= '0;
      gate_open <= 1'b0;
      lat_addr  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= bank_nxt[i];
      end
      q         <= bank[raddr];
      dirty     <= dirty_nxt;
      gate_open <= gate_open_nxt;
      lat_addr  <= lat_addr_nxt;
      if ((|wr_mask) && (wr_count != 8'hFF)) begin
        wr_count <= wr_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_d_latch_bank.sv
// tb/tb_d_latch_bank.sv - randomized bench for d_latch_bank against a behavioural bank model
// Directed test-plan sequences with literal checks, then random traffic; every cycle compared to the model.
module tb_d_latch_bank;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic [1:0] waddr;
  logic [1:0] raddr;
  logic [1:0] mode;
  logic       we;
  logic       gate;
  logic       clr_dirty;
  logic [7:0] q;
  logic [3:0] dirty;
  logic [7:0] wr_count;

  d_latch_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .d(d), .waddr(waddr), .raddr(raddr), .mode(mode),
    .we(we), .gate(gate), .clr_dirty(clr_dirty), .q(q), .dirty(dirty), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain array of channel values plus the latch window state.
  int       mb [DEPTH];
  int       nb [DEPTH];
  bit [3:0] wm;
  int       m_q, m_cnt, m_lat, tgt;
  bit [3:0] m_dirty;
  bit       m_open;

  always @(posedge clk) begin
    if (rst) begin
      foreach (mb[i]) mb[i] = 0;
      m_q = 0; m_cnt = 0; m_dirty = 0; m_open = 0; m_lat = 0;
    end else begin
      nb = mb;
      wm = 0;
      if (mode == 2'd0 && we) begin
        nb[waddr] = int'(d);
        wm[waddr] = 1;
      end else if (mode == 2'd1 && gate) begin
        tgt = m_open ? m_lat : int'(waddr);
        nb[tgt] = int'(d);
        wm[tgt] = 1;
        m_lat = tgt;
      end else if (mode == 2'd2 && we) begin
        for (int i = DEPTH - 1; i > 0; i--) nb[i] = mb[i-1];
        nb[0] = int'(d);
        wm = 4'hF;
      end
      m_open = (mode == 2'd1) && gate;
      if (clr_dirty) m_dirty[raddr] = 0;
      for (int i = 0; i < DEPTH; i++) if (wm[i] && nb[i] != mb[i]) m_dirty[i] = 1;
      if (wm != 0 && m_cnt < 255) m_cnt++;
      m_q = mb[raddr];
      mb = nb;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_q", 32'(q), 32'(m_q));
      chk("model_dirty", 32'(dirty), 32'(m_dirty));
      chk("model_wr_count", 32'(wr_count), 32'(m_cnt));
    end
  end

  task automatic tick(input logic r, input logic [1:0] m, input logic w, input logic g,
                      input logic [1:0] wa, input logic [1:0] ra, input logic [7:0] dd,
                      input logic c);
    rst = r; mode = m; we = w; gate = g; waddr = wa; raddr = ra; d = dd; clr_dirty = c;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mode = 2'd3; we = 0; gate = 0; waddr = 0; raddr = 0; d = 0; clr_dirty = 0;
    @(negedge clk);
    check_en = 1'b1;

    // Reset after loading every channel
    for (int i = 0; i < DEPTH; i++) tick(0, 2'd0, 1, 0, 2'(i), 0, 8'(8'h10 + i), 0);
    tick(1, 2'd0, 1, 0, 0, 0, 8'hFF, 0);
    chk("reset_q", 32'(q), 0);
    chk("reset_dirty", 32'(dirty), 0);
    chk("reset_wr_count", 32'(wr_count), 0);
    for (int i = 0; i < DEPTH; i++) begin
      tick(0, 2'd3, 0, 0, 0, 2'(i), 0, 0);
      chk("reset_read", 32'(q), 0);
    end

    // Capture
    tick(0, 2'd0, 1, 0, 2'd2, 2'd2, 8'hA5, 0);
    chk("cap_dirty", 32'(dirty), 32'h4);
    chk("cap_wr_count", 32'(wr_count), 1);
    tick(0, 2'd3, 0, 0, 0, 2'd2, 0, 0);
    chk("cap_q", 32'(q), 32'hA5);
    tick(0, 2'd0, 1, 0, 2'd2, 2'd2, 8'hA5, 0);
    chk("cap_rewrite_dirty", 32'(dirty), 32'h4);
    chk("cap_rewrite_wr_count", 32'(wr_count), 2);

    // Latch window locks onto the opening address
    tick(0, 2'd1, 0, 1, 2'd1, 0, 8'h11, 0);
    tick(0, 2'd1, 0, 1, 2'd3, 0, 8'h22, 0);
    tick(0, 2'd1, 0, 1, 2'd3, 0, 8'h33, 0);
    tick(0, 2'd1, 0, 0, 2'd3, 0, 8'h44, 0);
    tick(0, 2'd1, 0, 0, 2'd3, 2'd1, 8'h44, 0);
    chk("latch_ch1", 32'(q), 32'h33);
    tick(0, 2'd3, 0, 0, 0, 2'd3, 0, 0);
    chk("latch_ch3", 32'(q), 0);
    chk("latch_wr_count", 32'(wr_count), 5);

    // Shift chain
    tick(1, 2'd3, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) tick(0, 2'd2, 1, 0, 2'd3, 0, 8'(i), 0);
    chk("shift_wr_count", 32'(wr_count), 5);
    chk("shift_dirty", 32'(dirty), 32'hF);
    for (int i = 0; i < DEPTH; i++) begin
      tick(0, 2'd3, 0, 0, 0, 2'(i), 0, 0);
      chk("shift_read", 32'(q), 32'(5 - i));
    end

    // Freeze, then set-beats-clear on dirty
    for (int i = 0; i < 3; i++) tick(0, 2'd3, 1, 1, 2'(i), 0, 8'hEE, 0);
    chk("freeze_wr_count", 32'(wr_count), 5);
    tick(0, 2'd3, 0, 0, 0, 0, 0, 0);
    chk("freeze_ch0", 32'(q), 32'h5);
    tick(0, 2'd0, 1, 0, 2'd0, 2'd0, 8'h77, 1);
    chk("dirty_set_wins", 32'(dirty[0]), 1);
    tick(0, 2'd3, 0, 0, 0, 2'd1, 0, 1);
    chk("dirty_clear", 32'(dirty[1]), 0);

    // Saturation
    for (int i = 0; i < 300; i++)
      tick(0, 2'd0, 1, 0, 2'($urandom_range(0, 3)), 0, 8'($urandom), 0);
    chk("sat_wr_count", 32'(wr_count), 255);
    tick(0, 2'd0, 1, 0, 0, 0, 8'h5A, 0);
    chk("sat_hold", 32'(wr_count), 255);
    tick(1, 2'd0, 1, 0, 0, 0, 0, 0);
    chk("sat_reset", 32'(wr_count), 0);

    // Random traffic, latch mode weighted so windows stay open across cycles
    for (int n = 0; n < 3000; n++) begin
      tick(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 2) == 0) ? 2'd1 : 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           ($urandom_range(0, 3) == 0));
    end

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
